control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 clear  input  1  asynchronous active-low reset.
REQ-004 IR  input  32  instruction register contents; opcode = IR[31:27].
REQ-005 mem_ready  input  1  memory read data valid on MDR input this cycle.
REQ-006 stop  input  1  request halt at next instruction boundary.
REQ-007 PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, MDRin, MDRout, IRin  output  1 each  fetch-path controls to DataPath.
REQ-008 gra, grb, grc, rin, rout, RYin, HIout, LOout  output  1 each  register-select and execute controls to DataPath.
REQ-009 ops  output  5  ALU operation select to DataPath.
REQ-010 run  output  1  high while sequencing instructions.
REQ-011 fault  output  1  high in FAULT state (illegal opcode).

Function
REQ-012 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, HALT, FAULT; encoding is free.
REQ-013 Moore outputs SHALL hold: every control output not listed for a state is 0; ops = 0 except T4.
REQ-014 IDLE: all controls 0, run=0; next state T0 unconditionally.
REQ-015 T0: PCout, MARin, IncPC, RZin = 1; next T1.
REQ-016 T1: Read, MDRin = 1 every cycle in T1; stay in T1 while mem_ready=0.
REQ-017 T1 with mem_ready=1: RZLOout, PCin also 1 that cycle only; next T2 (PC updated exactly once per fetch regardless of wait length).
REQ-018 T2: MDRout, IRin = 1; next T3; opcode sampled from IR at T3, not T2.
REQ-019 Opcodes: add=00000, sub=00001, and=00010, or=00011, mfhi=10100, mflo=10101, nop=11010, halt=11011; all others illegal.
REQ-020 T3 ALU op (add/sub/and/or): grb, rout, RYin = 1; next T4.
REQ-021 T4 ALU op: grc, rout, RZin = 1, ops = IR[31:27]; next T5.
REQ-022 T5 ALU op: RZLOout, gra, rin = 1; next T0 (or HALT per REQ-026).
REQ-023 T3 mfhi: gra, rin, HIout = 1; mflo: gra, rin, LOout = 1; next T0 (or HALT).
REQ-024 T3 nop: no controls; next T0 (or HALT). T3 halt opcode: next HALT.
REQ-025 T3 illegal opcode: next FAULT; fault=1 in FAULT; FAULT and HALT exit only via clear.
REQ-026 stop sampled only at instruction end (last execute state); stop=1 there -> HALT instead of T0; stop elsewhere ignored, instruction completes.
REQ-027 run = 1 in T0..T5, 0 in IDLE, HALT, FAULT.
REQ-028 Latency from T0 entry, zero wait: ALU op 6 cycles, mfhi/mflo/nop 4 cycles; each mem_ready=0 cycle in T1 adds 1.
REQ-029 At most one of HIout, LOout, RZLOout, MDRout, PCout, rout SHALL be 1 in any cycle (single bus driver).

Reset
REQ-030 clear=0 SHALL force IDLE immediately, asynchronously, from any state including mid-T1 wait; all outputs 0, ops=0, run=0, fault=0.
REQ-031 First rising edge after clear deasserts SHALL move IDLE -> T0.

Verification
REQ-032 Release clear, mem_ready=1, IR=0xA1000000 (mfhi, ra=R2) -> T0,T1,T2,T3 in 4 cycles; T3 shows gra=rin=HIout=1, others 0; back to T0.
REQ-033 IR=0x00918000 (add), mem_ready=1 -> T3 grb/rout/RYin; T4 grc/rout/RZin, ops=00000; T5 RZLOout/gra/rin; 6 cycles total.
REQ-034 mem_ready=0 for 3 cycles in T1 -> Read=MDRin=1 for 4 cycles, PCin=RZLOout=1 only on 4th; T2 follows.
REQ-035 IR opcode 11111 -> FAULT after T3, fault=1, run=0, all controls 0 until clear.
REQ-036 stop=1 pulsed during T4 of sub (0x08...) -> T5 completes; stop low at T5 -> T0; stop=1 at T5 -> HALT, run=0.
REQ-037 clear=0 mid-T4 between edges -> outputs 0 within same cycle; after release, sequence restarts at T0.

Source files
------------

// File: rtl/control_sequencer.sv
// Instruction fetch/execute control sequencer for the DataPath.
// Walks IDLE -> T0..T5 per instruction and stops in HALT or FAULT until clear.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    input  logic        stop,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        RZin,
    output logic        RZLOout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        rin,
    output logic        rout,
    output logic        RYin,
    output logic        HIout,
    output logic        LOout,
    output logic [4:0]  ops,
    output logic        run,
    output logic        fault
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_T4    = 4'd5;
    localparam logic [3:0] S_T5    = 4'd6;
    localparam logic [3:0] S_HALT  = 4'd7;
    localparam logic [3:0] S_FAULT = 4'd8;

    localparam logic [4:0] OP_MFHI = 5'b10100;
    localparam logic [4:0] OP_MFLO = 5'b10101;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [4:0] w_op;
    logic       w_alu;
    logic       w_mfhi;
    logic       w_mflo;
    logic       w_nop;
    logic       w_halt;

    // Opcode decode is only consumed in T3/T4, so IR is read live there.
    assign w_op   = IR[31:27];
    assign w_alu  = (w_op[4:2] == 3'b000);
    assign w_mfhi = (w_op == OP_MFHI);
    assign w_mflo = (w_op == OP_MFLO);
    assign w_nop  = (w_op == OP_NOP);
    assign w_halt = (w_op == OP_HALT);

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = S_T0;
            S_T0:    w_next = S_T1;
            S_T1:    w_next = mem_ready ? S_T2 : S_T1;
            S_T2:    w_next = S_T3;
            S_T3: begin
                if (w_alu)
                    w_next = S_T4;
                else if (w_mfhi || w_mflo || w_nop)
                    w_next = stop ? S_HALT : S_T0;
                else if (w_halt)
                    w_next = S_HALT;
                else
                    w_next = S_FAULT;
            end
            S_T4:    w_next = S_T5;
            S_T5:    w_next = stop ? S_HALT : S_T0;
            S_HALT:  w_next = S_HALT;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        PCout   = 1'b0;
        MARin   = 1'b0;
        IncPC   = 1'b0;
        RZin    = 1'b0;
        RZLOout = 1'b0;
        PCin    = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        gra     = 1'b0;
        grb     = 1'b0;
        grc     = 1'b0;
        rin     = 1'b0;
        rout    = 1'b0;
        RYin    = 1'b0;
        HIout   = 1'b0;
        LOout   = 1'b0;
        ops     = 5'd0;
        run     = 1'b0;
        fault   = 1'b0;
        case (r_state)
            S_T0: begin
                run   = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                RZin  = 1'b1;
            end
            S_T1: begin
                run   = 1'b1;
                Read  = 1'b1;
                MDRin = 1'b1;
                // PC writeback only on the completing cycle so long waits load it once.
                RZLOout = mem_ready;
                PCin    = mem_ready;
            end
            S_T2: begin
                run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                run = 1'b1;
                if (w_alu) begin
                    grb  = 1'b1;
                    rout = 1'b1;
                    RYin = 1'b1;
                end else if (w_mfhi || w_mflo) begin
                    gra   = 1'b1;
                    rin   = 1'b1;
                    HIout = w_mfhi;
                    LOout = w_mflo;
                end
            end
            S_T4: begin
                run  = 1'b1;
                grc  = 1'b1;
                rout = 1'b1;
                RZin = 1'b1;
                ops  = w_op;
            end
            S_T5: begin
                run     = 1'b1;
                RZLOout = 1'b1;
                gra     = 1'b1;
                rin     = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a directed instruction table, hand sequences for
// stop/clear corners, then random instructions checked against a per-instruction trace model.
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic [31:0] IR;
    logic        mem_ready;
    logic        stop;
    logic PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, MDRin, MDRout, IRin;
    logic gra, grb, grc, rin, rout, RYin, HIout, LOout;
    logic [4:0] ops;
    logic run, fault;

    control_sequencer dut (
        .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready), .stop(stop),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .RZin(RZin), .RZLOout(RZLOout),
        .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .RYin(RYin),
        .HIout(HIout), .LOout(LOout), .ops(ops), .run(run), .fault(fault)
    );

    typedef struct packed {
        logic PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, MDRin, MDRout, IRin;
        logic gra, grb, grc, rin, rout, RYin, HIout, LOout;
        logic [4:0] ops;
        logic run, fault;
    } outs_t;

    typedef struct {
        outs_t exp;
        logic  mr;
        logic  st;
    } step_t;

    typedef struct {
        logic [31:0] ir;
        int          nwait;
        logic        stop_end;
        int          exp_cycles;
        int          exp_end;    // 0: back to T0, 1: HALT, 2: FAULT
    } vec_t;

    outs_t act;
    assign act = {PCout, MARin, IncPC, RZin, RZLOout, PCin, Read, MDRin, MDRout, IRin,
                  gra, grb, grc, rin, rout, RYin, HIout, LOout, ops, run, fault};

    int    n_vec = 0;
    int    n_err = 0;
    int    run_cnt;
    step_t tq[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input outs_t e);
        n_vec++;
        if (act !== e) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", nm, act, e);
        end
        n_vec++;
        if ($countones({HIout, LOout, RZLOout, MDRout, PCout, rout}) > 1) begin
            n_err++;
            $display("FAIL %s bus: drivers %b exp at most one",
                     nm, {HIout, LOout, RZLOout, MDRout, PCout, rout});
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d exp %0d", nm, got, exp);
        end
    endtask

    function automatic logic rnd_bit(input logic noise, input logic dflt);
        return noise ? 1'($urandom_range(0, 1)) : dflt;
    endfunction

    // Expected per-cycle trace of one instruction, from T0 entry to the last execute cycle.
    task automatic build(input logic [31:0] ir, input int nwait, input logic stop_end,
                         input logic noise, output int endk);
        outs_t o;
        logic [4:0] op;
        op = ir[31:27];
        tq.delete();
        o = '0; o.run = 1; o.PCout = 1; o.MARin = 1; o.IncPC = 1; o.RZin = 1;
        tq.push_back('{o, rnd_bit(noise, 1'b1), rnd_bit(noise, 1'b0)});
        for (int i = 0; i < nwait; i++) begin
            o = '0; o.run = 1; o.Read = 1; o.MDRin = 1;
            tq.push_back('{o, 1'b0, rnd_bit(noise, 1'b0)});
        end
        o = '0; o.run = 1; o.Read = 1; o.MDRin = 1; o.RZLOout = 1; o.PCin = 1;
        tq.push_back('{o, 1'b1, rnd_bit(noise, 1'b0)});
        o = '0; o.run = 1; o.MDRout = 1; o.IRin = 1;
        tq.push_back('{o, rnd_bit(noise, 1'b1), rnd_bit(noise, 1'b0)});
        endk = stop_end ? 1 : 0;
        o = '0; o.run = 1;
        if (op <= 5'd3) begin
            o.grb = 1; o.rout = 1; o.RYin = 1;
            tq.push_back('{o, rnd_bit(noise, 1'b1), rnd_bit(noise, 1'b0)});
            o = '0; o.run = 1; o.grc = 1; o.rout = 1; o.RZin = 1; o.ops = op;
            tq.push_back('{o, rnd_bit(noise, 1'b1), rnd_bit(noise, 1'b0)});
            o = '0; o.run = 1; o.RZLOout = 1; o.gra = 1; o.rin = 1;
        end else if (op == 5'b10100) begin
            o.gra = 1; o.rin = 1; o.HIout = 1;
        end else if (op == 5'b10101) begin
            o.gra = 1; o.rin = 1; o.LOout = 1;
        end else if (op == 5'b11011) begin
            endk = 1;
        end else if (op != 5'b11010) begin
            endk = 2;
        end
        tq.push_back('{o, rnd_bit(noise, 1'b1), stop_end});
    endtask

    // Starts at T0 (posedge+1); if abort_at hits, clear is pulsed mid-cycle there.
    task automatic apply(input string nm, input int abort_at);
        outs_t z;
        z = '0;
        run_cnt = 0;
        foreach (tq[i]) begin
            mem_ready = tq[i].mr;
            stop      = tq[i].st;
            #2;
            check($sformatf("%s c%0d", nm, i), tq[i].exp);
            if (run) run_cnt++;
            if (i == abort_at) begin
                clear = 1'b0;
                #1;
                check($sformatf("%s async clear", nm), z);
                #2;
                clear = 1'b1;
                @(posedge clock); #1;
                return;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic do_clear(input string nm);
        outs_t z;
        z = '0;
        clear = 1'b0;
        #1;
        check($sformatf("%s reset", nm), z);
        #3;
        clear = 1'b1;
        #1;
        check($sformatf("%s idle", nm), z);
        @(posedge clock); #1;
    endtask

    task automatic terminal(input string nm, input int endk);
        outs_t e;
        e = '0;
        e.fault = (endk == 2);
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            stop      = 1'($urandom_range(0, 1));
            #2;
            check($sformatf("%s term%0d", nm, i), e);
            @(posedge clock); #1;
        end
        do_clear(nm);
    endtask

    vec_t tbl[12];

    initial begin
        int endk;
        logic [4:0] legal[8];
        logic [4:0] op;
        tbl[0]  = '{32'hA1000000, 0, 1'b0, 4, 0};  // mfhi
        tbl[1]  = '{32'h00918000, 0, 1'b0, 6, 0};  // add
        tbl[2]  = '{32'h00918000, 3, 1'b0, 9, 0};  // add, 3 wait cycles
        tbl[3]  = '{32'hA8000000, 1, 1'b0, 5, 0};  // mflo
        tbl[4]  = '{32'hD0000000, 0, 1'b0, 4, 0};  // nop
        tbl[5]  = '{32'h10000000, 2, 1'b0, 8, 0};  // and
        tbl[6]  = '{32'h18000000, 0, 1'b0, 6, 0};  // or
        tbl[7]  = '{32'h08000000, 0, 1'b1, 6, 1};  // sub, stop at T5
        tbl[8]  = '{32'hD8000000, 0, 1'b0, 4, 1};  // halt opcode
        tbl[9]  = '{32'hF8000000, 0, 1'b0, 4, 2};  // illegal 11111
        tbl[10] = '{32'hA1000000, 0, 1'b1, 4, 1};  // mfhi, stop at T3
        tbl[11] = '{32'h20000000, 1, 1'b0, 5, 2};  // illegal 00100
        legal = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                  5'b10100, 5'b10101, 5'b11010, 5'b11011};

        IR = 32'h0; mem_ready = 1'b1; stop = 1'b0; clear = 1'b0;
        @(posedge clock); #1;
        do_clear("init");

        foreach (tbl[k]) begin
            IR = tbl[k].ir;
            build(tbl[k].ir, tbl[k].nwait, tbl[k].stop_end, 1'b0, endk);
            apply($sformatf("tbl%0d", k), -1);
            check_int($sformatf("tbl%0d cycles", k), run_cnt, tbl[k].exp_cycles);
            if (tbl[k].exp_end != 0) terminal($sformatf("tbl%0d", k), tbl[k].exp_end);
        end

        // stop during T4 of sub is ignored when low at T5
        IR = 32'h08000000;
        build(IR, 0, 1'b0, 1'b0, endk);
        tq[4].st = 1'b1;
        apply("sub stopT4", -1);
        build(32'hA1000000, 0, 1'b0, 1'b0, endk);
        IR = 32'hA1000000;
        apply("after stopT4", -1);

        // asynchronous clear in the middle of T4, then restart
        IR = 32'h00918000;
        build(IR, 0, 1'b0, 1'b0, endk);
        apply("clear midT4", 4);
        build(IR, 0, 1'b0, 1'b0, endk);
        apply("restart", -1);
        check_int("restart cycles", run_cnt, 6);

        // clear during a T1 wait
        build(IR, 5, 1'b0, 1'b0, endk);
        apply("clear midT1", 3);

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = 5'($urandom);
                while (op[4:2] == 3'b000 || op == 5'b10100 || op == 5'b10101 ||
                       op == 5'b11010 || op == 5'b11011);
            end else begin
                op = legal[$urandom_range(0, 7)];
            end
            IR = {op, 27'($urandom)};
            build(IR, $urandom_range(0, 4), ($urandom_range(0, 7) == 0), 1'b1, endk);
            apply($sformatf("rnd%0d op%b", r, op), -1);
            if (endk != 0) terminal($sformatf("rnd%0d", r), endk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
